multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  7  instruction register bits [6:0].
REQ-005 funct_3  input  3  instruction register bits [14:12].
REQ-006 funct_7_5  input  1  instruction register bit 30.
REQ-007 zero  input  1  ALU zero flag from the current cycle.
REQ-008 mem_ready  input  1  memory completes the access requested this cycle.
REQ-009 mem_req  output  1  memory access request; held until mem_ready.
REQ-010 mem_write  output  1  the current request is a store.
REQ-011 adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-012 ir_write  output  1  load the instruction register and old-PC register.
REQ-013 pc_write  output  1  PC register enable.
REQ-014 reg_write  output  1  register-file write enable.
REQ-015 alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
REQ-016 alu_src_b  output  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-017 result_src  output  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
REQ-018 alu_ctrl  output  3  ALU operation code.
REQ-019 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-020 illegal_instr  output  1  one-cycle pulse when the decoded opcode is unsupported.

Function
REQ-021 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH and JAL; all outputs not listed for a state are 0 or 00.
REQ-022 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, alu_op=00; ir_write=pc_write=mem_ready; go to DECODE on mem_ready, otherwise stay.
REQ-023 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut); next state by opcode: 0000011 or 0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, any other -> FETCH with illegal_instr=1.
REQ-024 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; go to MEMREAD if opcode[5]=0, else MEMWRITE.
REQ-025 MEMREAD: mem_req=1, adr_src=1; go to MEMWB on mem_ready, otherwise stay.
REQ-026 MEMWB: result_src=01, reg_write=1, instr_done=1; go to FETCH.
REQ-027 MEMWRITE: mem_req=1, mem_write=1, adr_src=1; on mem_ready set instr_done=1 and go to FETCH, otherwise stay.
REQ-028 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10; EXECI: alu_src_a=10, alu_src_b=01, alu_op=10; both go to ALUWB.
REQ-029 ALUWB: result_src=00, reg_write=1, instr_done=1; go to FETCH.
REQ-030 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, instr_done=1; pc_write = branch_neg ? zero : ~zero; go to FETCH.
REQ-031 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; go to ALUWB.
REQ-032 alu_ctrl and branch_neg SHALL come combinationally from the 2-bit internal alu_op together with funct_3, opcode[5] and funct_7_5, using the standard ALU decode table.
REQ-033 An unsupported branch funct_3 (decoded alu_ctrl = x) SHALL produce pc_write=0 and SHALL still retire.
REQ-034 mem_write SHALL be asserted only while mem_req=1; the request outputs SHALL stay stable while mem_ready=0.

Reset
REQ-035 On rst_n low the state SHALL be FETCH immediately, including in the middle of any state.
REQ-036 While rst_n is low, mem_req, mem_write, ir_write, pc_write, reg_write, instr_done and illegal_instr SHALL be 0.
REQ-037 After reset the first request SHALL be a fetch in the first cycle in which rst_n is high.

Structure
REQ-038 Package rvscc_ctrl_pkg SHALL hold the state enum, the opcode constants and the alu_src_a, alu_src_b and result_src encodings.
REQ-039 The block SHALL instantiate exactly one alu_decoder sub-module for alu_ctrl and branch_neg.

Verification
REQ-040 add x3,x1,x2 with mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; alu_ctrl=000; reg_write and instr_done in cycle 4.
REQ-041 lw with mem_ready low for 3 cycles in MEMREAD -> mem_req and adr_src=1 are held for 4 cycles; MEMWB follows; retires in 5+3 cycles.
REQ-042 sw -> mem_write=1 only in MEMWRITE; no reg_write; instr_done on the mem_ready cycle.
REQ-043 beq with zero=1 -> pc_write=1 in BRANCH; bge (funct_3=101) with zero=0 -> pc_write=0; blt with zero=0 -> pc_write=1.
REQ-044 opcode 0000000 -> illegal_instr pulse in DECODE, return to FETCH, no write enables.
REQ-045 rst_n pulled low in MEMWRITE while mem_ready=0 -> mem_req and mem_write drop asynchronously; after release the FSM is in FETCH with mem_req=1.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
package rvscc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10} src_a_t;
    typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} src_b_t;
    typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEMDATA = 2'b01, RES_ALU = 2'b10} result_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    // Per-state control word; input-dependent enables are qualified outside.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       fetch;
        logic       decode;
        logic       jal;
        logic       branch;
        logic       reg_write;
        logic       retire;
        logic       retire_on_ready;
        src_a_t     a;
        src_b_t     b;
        result_t    res;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c.mem_req = 1'b0; c.mem_write = 1'b0; c.adr_src = 1'b0;
        c.fetch = 1'b0; c.decode = 1'b0; c.jal = 1'b0; c.branch = 1'b0;
        c.reg_write = 1'b0; c.retire = 1'b0; c.retire_on_ready = 1'b0;
        c.a = SRCA_PC; c.b = SRCB_RS2; c.res = RES_ALUOUT; c.alu_op = ALUOP_ADD;
        case (s)
            S_FETCH: begin
                c.mem_req = 1'b1; c.fetch = 1'b1; c.b = SRCB_FOUR; c.res = RES_ALU;
            end
            S_DECODE:   begin c.decode = 1'b1; c.a = SRCA_OLDPC; c.b = SRCB_IMM; end
            S_MEMADR:   begin c.a = SRCA_RS1; c.b = SRCB_IMM; end
            S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            S_MEMWB:    begin c.res = RES_MEMDATA; c.reg_write = 1'b1; c.retire = 1'b1; end
            S_MEMWRITE: begin
                c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; c.retire_on_ready = 1'b1;
            end
            S_EXECR:    begin c.a = SRCA_RS1; c.b = SRCB_RS2; c.alu_op = ALUOP_FUNCT; end
            S_EXECI:    begin c.a = SRCA_RS1; c.b = SRCB_IMM; c.alu_op = ALUOP_FUNCT; end
            S_ALUWB:    begin c.reg_write = 1'b1; c.retire = 1'b1; end
            S_BRANCH:   begin
                c.a = SRCA_RS1; c.b = SRCB_RS2; c.alu_op = ALUOP_BRANCH;
                c.branch = 1'b1; c.retire = 1'b1;
            end
            S_JAL:      begin c.a = SRCA_OLDPC; c.b = SRCB_FOUR; c.jal = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory request handshake between the controller and the memory.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
    modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode; branch_ok flags a supported branch funct_3.
module alu_decoder
    import rvscc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct_3,
    input  logic       op_5,
    input  logic       funct_7_5,
    output logic [2:0] alu_ctrl,
    output logic       branch_neg,
    output logic       branch_ok
);

    always_comb begin
        alu_ctrl   = ALU_ADD;
        branch_neg = 1'b0;
        branch_ok  = 1'b0;
        case (alu_op)
            ALUOP_BRANCH: begin
                branch_ok = 1'b1;
                // branch_neg: taken when the compare result is zero
                case (funct_3)
                    3'b000:  begin alu_ctrl = ALU_SUB;  branch_neg = 1'b1; end
                    3'b001:  begin alu_ctrl = ALU_SUB;  branch_neg = 1'b0; end
                    3'b100:  begin alu_ctrl = ALU_SLT;  branch_neg = 1'b0; end
                    3'b101:  begin alu_ctrl = ALU_SLT;  branch_neg = 1'b1; end
                    3'b110:  begin alu_ctrl = ALU_SLTU; branch_neg = 1'b0; end
                    3'b111:  begin alu_ctrl = ALU_SLTU; branch_neg = 1'b1; end
                    default: branch_ok = 1'b0;
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct_3)
                    3'b000:  alu_ctrl = (op_5 & funct_7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: per-state control word is registered alongside the state.
module multicycle_controller
    import rvscc_ctrl_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    multicycle_controller_if.master        mem,
    input  logic [6:0]                     opcode,
    input  logic [2:0]                     funct_3,
    input  logic                           funct_7_5,
    input  logic                           zero,
    output logic                           ir_write,
    output logic                           pc_write,
    output logic                           reg_write,
    output logic [1:0]                     alu_src_a,
    output logic [1:0]                     alu_src_b,
    output logic [1:0]                     result_src,
    output logic [2:0]                     alu_ctrl,
    output logic                           instr_done,
    output logic                           illegal_instr
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   op_legal;
    logic   branch_neg, branch_ok, branch_taken, fetch_done;

    always_comb begin
        op_legal = opcode inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL};
        state_d  = state_q;
        case (state_q)
            S_FETCH:    if (mem.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem.mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem.mem_ready) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL:     state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
        ctrl_d = state_ctrl(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op     (ctrl_q.alu_op),
        .funct_3    (funct_3),
        .op_5       (opcode[5]),
        .funct_7_5  (funct_7_5),
        .alu_ctrl   (alu_ctrl),
        .branch_neg (branch_neg),
        .branch_ok  (branch_ok)
    );

    // Enables are forced low by rst_n so they drop without waiting for a clock.
    assign fetch_done    = ctrl_q.fetch & mem.mem_ready;
    assign branch_taken  = branch_ok & (branch_neg ? zero : ~zero);
    assign mem.mem_req   = rst_n & ctrl_q.mem_req;
    assign mem.mem_write = rst_n & ctrl_q.mem_write;
    assign mem.adr_src   = ctrl_q.adr_src;
    assign ir_write      = rst_n & fetch_done;
    assign pc_write      = rst_n & (fetch_done | ctrl_q.jal | (ctrl_q.branch & branch_taken));
    assign reg_write     = rst_n & ctrl_q.reg_write;
    assign instr_done    = rst_n & (ctrl_q.retire | (ctrl_q.retire_on_ready & mem.mem_ready));
    assign illegal_instr = rst_n & ctrl_q.decode & ~op_legal;
    assign alu_src_a     = ctrl_q.a;
    assign alu_src_b     = ctrl_q.b;
    assign result_src    = ctrl_q.res;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded per-cycle check of the multicycle controller outputs.
module tb_multicycle_controller;

    localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3, T_MEMWB = 4,
                   T_MEMWRITE = 5, T_EXECR = 6, T_EXECI = 7, T_ALUWB = 8, T_BRANCH = 9,
                   T_JAL = 10, T_DECILL = 11;

    typedef struct {
        int         st;
        logic       rdy;
        logic       z;
        logic [2:0] ac;
        logic       pcw;
        logic       chk_ac;
    } step_t;

    typedef struct packed {
        logic [16:0] v;
        logic [16:0] m;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct_3;
    logic       funct_7_5;
    logic       zero;
    logic       ir_write, pc_write, reg_write, instr_done, illegal_instr;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_ctrl;
    logic [16:0] outs;
    logic [6:0]  enables;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    multicycle_controller_if mif ();

    multicycle_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem           (mif),
        .opcode        (opcode),
        .funct_3       (funct_3),
        .funct_7_5     (funct_7_5),
        .zero          (zero),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .alu_ctrl      (alu_ctrl),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    assign outs = {mif.mem_req, mif.mem_write, mif.adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_src, alu_ctrl, instr_done, illegal_instr};
    assign enables = {mif.mem_req, mif.mem_write, ir_write, pc_write, reg_write,
                      instr_done, illegal_instr};

    function automatic step_t mk(input int st, input logic rdy, input logic z,
                                 input logic [2:0] ac, input logic pcw, input logic chk_ac);
        step_t s;
        s.st = st; s.rdy = rdy; s.z = z; s.ac = ac; s.pcw = pcw; s.chk_ac = chk_ac;
        return s;
    endfunction

    // Expected outputs written straight from the per-state output table.
    function automatic exp_t expect_cycle(input step_t s);
        logic req, wr, adr, irw, pcw, rw, done, ill;
        logic [1:0] a, b, res;
        exp_t e;
        {req, wr, adr, irw, pcw, rw, done, ill} = '0;
        a = 2'b00; b = 2'b00; res = 2'b00;
        case (s.st)
            T_FETCH:    begin req = 1; irw = s.rdy; pcw = s.rdy; b = 2'b10; res = 2'b10; end
            T_DECODE:   begin a = 2'b01; b = 2'b01; end
            T_DECILL:   begin a = 2'b01; b = 2'b01; ill = 1; end
            T_MEMADR:   begin a = 2'b10; b = 2'b01; end
            T_MEMREAD:  begin req = 1; adr = 1; end
            T_MEMWB:    begin res = 2'b01; rw = 1; done = 1; end
            T_MEMWRITE: begin req = 1; wr = 1; adr = 1; done = s.rdy; end
            T_EXECR:    begin a = 2'b10; b = 2'b00; end
            T_EXECI:    begin a = 2'b10; b = 2'b01; end
            T_ALUWB:    begin rw = 1; done = 1; end
            T_BRANCH:   begin a = 2'b10; done = 1; pcw = s.pcw; end
            T_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
            default: ;
        endcase
        e.v = {req, wr, adr, irw, pcw, rw, a, b, res, s.ac, done, ill};
        e.m = s.chk_ac ? 17'h1ffff : 17'h1ffe3;
        return e;
    endfunction

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode = op; funct_3 = f3; funct_7_5 = f7;
    endtask

    task automatic drive_cycle(input step_t s);
        mif.mem_ready = s.rdy;
        zero = s.z;
        sb.push_back(expect_cycle(s));
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [16:0] got;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (enables !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_enables got=%b want=0000000", enables);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sb.push_back(expect_cycle(mk(T_FETCH, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1)));
        e = sb.pop_front(); got = outs;
        n_cmp++;
        if ((got & e.m) !== (e.v & e.m)) begin
            n_fail++;
            $display("FAIL reset_release got=%b want=%b", got, e.v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        step_t s[$];
        exp_t e;
        logic [16:0] got;
        int k;
        logic [6:0] ops[4] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011};
        logic [2:0] f3s[4] = '{3'b000, 3'b000, 3'b000, 3'b110};
        logic       f7s[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0] acs[4] = '{3'b000, 3'b001, 3'b000, 3'b011};
        for (int t = 0; t < 4; t++) begin
            set_instr(ops[t], f3s[t], f7s[t]);
            s.delete();
            s.push_back(mk(T_FETCH, 1, 0, 3'b000, 0, 1));
            s.push_back(mk(T_DECODE, 1, 0, 3'b000, 0, 1));
            s.push_back(mk(ops[t][5] ? T_EXECR : T_EXECI, 1, 0, acs[t], 0, 1));
            s.push_back(mk(T_ALUWB, 1, 0, 3'b000, 0, 1));
            k = 0;
            foreach (s[i]) begin
                drive_cycle(s[i]);
                e = sb.pop_front(); got = outs;
                n_cmp++;
                if ((got & e.m) !== (e.v & e.m)) begin
                    n_fail++;
                    $display("FAIL alu%0d cycle %0d got=%b want=%b", t, k, got, e.v);
                end
                k++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_load();
        step_t s[$];
        exp_t e;
        logic [16:0] got;
        int k = 0;
        set_instr(7'b0000011, 3'b010, 1'b0);
        s.push_back(mk(T_FETCH, 1, 0, 3'b000, 0, 1));
        s.push_back(mk(T_DECODE, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_MEMADR, 0, 0, 3'b000, 0, 1));
        for (int i = 0; i < 3; i++) s.push_back(mk(T_MEMREAD, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_MEMREAD, 1, 0, 3'b000, 0, 1));
        s.push_back(mk(T_MEMWB, 0, 0, 3'b000, 0, 1));
        foreach (s[i]) begin
            drive_cycle(s[i]);
            e = sb.pop_front(); got = outs;
            n_cmp++;
            if ((got & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL lw cycle %0d got=%b want=%b", k, got, e.v);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        step_t s[$];
        exp_t e;
        logic [16:0] got;
        int k = 0;
        set_instr(7'b0100011, 3'b010, 1'b0);
        s.push_back(mk(T_FETCH, 1, 0, 3'b000, 0, 1));
        s.push_back(mk(T_DECODE, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_MEMADR, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_MEMWRITE, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_MEMWRITE, 1, 0, 3'b000, 0, 1));
        s.push_back(mk(T_FETCH, 0, 0, 3'b000, 0, 1));
        foreach (s[i]) begin
            drive_cycle(s[i]);
            e = sb.pop_front(); got = outs;
            n_cmp++;
            if ((got & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL sw cycle %0d got=%b want=%b", k, got, e.v);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        step_t s[$];
        exp_t e;
        logic [16:0] got;
        int k;
        // beq z=1, bge z=0, blt z=0, bne z=0, bltu z=1, unsupported f3=010
        logic [2:0] f3s[6] = '{3'b000, 3'b101, 3'b100, 3'b001, 3'b110, 3'b010};
        logic       zs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0] acs[6] = '{3'b001, 3'b101, 3'b101, 3'b001, 3'b110, 3'b000};
        logic       pcs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       cks[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 6; t++) begin
            set_instr(7'b1100011, f3s[t], 1'b0);
            s.delete();
            s.push_back(mk(T_FETCH, 1, ~zs[t], 3'b000, 0, 1));
            s.push_back(mk(T_DECODE, 0, ~zs[t], 3'b000, 0, 1));
            s.push_back(mk(T_BRANCH, 0, zs[t], acs[t], pcs[t], cks[t]));
            k = 0;
            foreach (s[i]) begin
                drive_cycle(s[i]);
                e = sb.pop_front(); got = outs;
                n_cmp++;
                if ((got & e.m) !== (e.v & e.m)) begin
                    n_fail++;
                    $display("FAIL branch%0d cycle %0d got=%b want=%b", t, k, got, e.v);
                end
                k++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_jal();
        step_t s[$];
        exp_t e;
        logic [16:0] got;
        int k = 0;
        set_instr(7'b1101111, 3'b000, 1'b0);
        s.push_back(mk(T_FETCH, 1, 0, 3'b000, 0, 1));
        s.push_back(mk(T_DECODE, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_JAL, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_ALUWB, 0, 0, 3'b000, 0, 1));
        foreach (s[i]) begin
            drive_cycle(s[i]);
            e = sb.pop_front(); got = outs;
            n_cmp++;
            if ((got & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL jal cycle %0d got=%b want=%b", k, got, e.v);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        step_t s[$];
        exp_t e;
        logic [16:0] got;
        int k = 0;
        set_instr(7'b0000000, 3'b000, 1'b0);
        s.push_back(mk(T_FETCH, 1, 0, 3'b000, 0, 1));
        s.push_back(mk(T_DECILL, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_FETCH, 0, 0, 3'b000, 0, 1));
        foreach (s[i]) begin
            drive_cycle(s[i]);
            e = sb.pop_front(); got = outs;
            n_cmp++;
            if ((got & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL illegal cycle %0d got=%b want=%b", k, got, e.v);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_stall();
        step_t s[$];
        exp_t e;
        logic [16:0] got;
        int k = 0;
        set_instr(7'b0110011, 3'b111, 1'b0);
        s.push_back(mk(T_FETCH, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_FETCH, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_FETCH, 1, 0, 3'b000, 0, 1));
        s.push_back(mk(T_DECODE, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_EXECR, 0, 0, 3'b010, 0, 1));
        s.push_back(mk(T_ALUWB, 0, 0, 3'b000, 0, 1));
        foreach (s[i]) begin
            drive_cycle(s[i]);
            e = sb.pop_front(); got = outs;
            n_cmp++;
            if ((got & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL fetch_stall cycle %0d got=%b want=%b", k, got, e.v);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midwrite();
        step_t s[$];
        exp_t e;
        logic [16:0] got;
        int k = 0;
        set_instr(7'b0100011, 3'b010, 1'b0);
        s.push_back(mk(T_FETCH, 1, 0, 3'b000, 0, 1));
        s.push_back(mk(T_DECODE, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_MEMADR, 0, 0, 3'b000, 0, 1));
        s.push_back(mk(T_MEMWRITE, 0, 0, 3'b000, 0, 1));
        foreach (s[i]) begin
            drive_cycle(s[i]);
            e = sb.pop_front(); got = outs;
            n_cmp++;
            if ((got & e.m) !== (e.v & e.m)) begin
                n_fail++;
                $display("FAIL midwrite cycle %0d got=%b want=%b", k, got, e.v);
            end
            k++;
            if (i < 3) begin @(posedge clk); #1; end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (enables !== 7'b0) begin
            n_fail++;
            $display("FAIL midwrite_async_reset got=%b want=0000000", enables);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sb.push_back(expect_cycle(mk(T_FETCH, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1)));
        e = sb.pop_front(); got = outs;
        n_cmp++;
        if ((got & e.m) !== (e.v & e.m)) begin
            n_fail++;
            $display("FAIL midwrite_release got=%b want=%b", got, e.v);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b1;
        mif.mem_ready = 1'b0;
        zero = 1'b0;
        set_instr(7'b0, 3'b0, 1'b0);
        #2;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_jal();
        test_illegal();
        test_fetch_stall();
        test_reset_midwrite();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
